// File: rtl/mem_access_stage.sv
// Data-memory access stage: forwards the EX/MEM bundle to MEM/WB and performs loads/stores on a local word memory.
// Latency: 1 falling edge for ALU ops and dropped misaligned accesses, WAIT_CYCLES+1 for aligned loads/stores.
// Backpressure: stall holds the upstream stages during memory waits; there is no downstream backpressure.
module mem_access_stage #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem2reg_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] mem_write_data_in,
    input  logic [4:0]  dst_addr_in,
    output logic        stall,
    output logic        wb_out,
    output logic        mem2reg_out,
    output logic [31:0] mem_read_data_out,
    output logic [31:0] ALU_result_out,
    output logic [4:0]  dst_addr_out,
    output logic        mem_fault
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  req, aligned, complete, stall_c, mem_we;
    logic                  wb_d, m2r_d, fault_d;
    logic [4:0]            dst_d;
    logic [31:0]           rdata_d;

    assign idx     = ALU_result_in[DEPTH_LOG2+1:2];
    assign req     = mem_read_in | mem_write_in;
    assign aligned = (ALU_result_in[1:0] == 2'b00);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        complete = 1'b0;
        fault_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!req) begin
                    complete = 1'b1;
                end else if (!aligned) begin
                    fault_d = 1'b1;
                end else if (NO_WAIT) begin
                    complete = 1'b1;
                end else begin
                    state_d = BUSY;
                    cnt_d   = WAIT_INIT;
                    stall_c = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                    stall_c = 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Anything not completing this edge (wait, dropped access) emits a bubble.
        wb_d    = complete & wb_in;
        m2r_d   = complete & mem2reg_in;
        dst_d   = complete ? dst_addr_in : 5'd0;
        mem_we  = complete & mem_write_in & aligned;
        rdata_d = (complete && mem_read_in && !mem_write_in) ? mem[idx] : 32'd0;
    end

    assign stall = stall_c & ~rst;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= 4'd0;
            wb_out            <= 1'b0;
            mem2reg_out       <= 1'b0;
            mem_read_data_out <= 32'd0;
            ALU_result_out    <= 32'd0;
            dst_addr_out      <= 5'd0;
            mem_fault         <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            wb_out            <= wb_d;
            mem2reg_out       <= m2r_d;
            mem_read_data_out <= rdata_d;
            ALU_result_out    <= ALU_result_in;
            dst_addr_out      <= dst_d;
            mem_fault         <= fault_d;
        end
    end

    // Memory has no reset; a store aborted by reset must never land.
    always_ff @(negedge clk) begin
        if (mem_we && !rst) begin
            mem[idx] <= mem_write_data_in;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: unit 0 uses WAIT_CYCLES=2, unit 1 uses WAIT_CYCLES=0.
// Directed scenarios followed by random traffic checked against an address-indexed memory model.
module tb_mem_access_stage;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_i, rd_i, wr_i, m2r_i;
    logic [31:0] alu_i [2];
    logic [31:0] wd_i  [2];
    logic [4:0]  dst_i [2];
    logic [1:0]  stall_o, wb_o, m2r_o, fault_o;
    logic [31:0] rdata_o [2];
    logic [31:0] alu_o   [2];
    logic [4:0]  dst_o   [2];

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] mref [int];

    always #5 clk = ~clk;

    mem_access_stage #(.WAIT_CYCLES(2), .DEPTH_LOG2(8)) dut (
        .clk(clk), .rst(rst),
        .wb_in(wb_i[0]), .mem_read_in(rd_i[0]), .mem_write_in(wr_i[0]), .mem2reg_in(m2r_i[0]),
        .ALU_result_in(alu_i[0]), .mem_write_data_in(wd_i[0]), .dst_addr_in(dst_i[0]),
        .stall(stall_o[0]), .wb_out(wb_o[0]), .mem2reg_out(m2r_o[0]),
        .mem_read_data_out(rdata_o[0]), .ALU_result_out(alu_o[0]),
        .dst_addr_out(dst_o[0]), .mem_fault(fault_o[0])
    );

    mem_access_stage #(.WAIT_CYCLES(0), .DEPTH_LOG2(8)) dut0 (
        .clk(clk), .rst(rst),
        .wb_in(wb_i[1]), .mem_read_in(rd_i[1]), .mem_write_in(wr_i[1]), .mem2reg_in(m2r_i[1]),
        .ALU_result_in(alu_i[1]), .mem_write_data_in(wd_i[1]), .dst_addr_in(dst_i[1]),
        .stall(stall_o[1]), .wb_out(wb_o[1]), .mem2reg_out(m2r_o[1]),
        .mem_read_data_out(rdata_o[1]), .ALU_result_out(alu_o[1]),
        .dst_addr_out(dst_o[1]), .mem_fault(fault_o[1])
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int u, input bit rd, input bit wr, input bit wb, input bit m2r,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst);
        rd_i[u]  = rd;
        wr_i[u]  = wr;
        wb_i[u]  = wb;
        m2r_i[u] = m2r;
        alu_i[u] = a;
        wd_i[u]  = d;
        dst_i[u] = dst;
    endtask

    task automatic check_zero(input int u, input string tag);
        check({tag, ":wb0"},    wb_o[u],    0);
        check({tag, ":m2r0"},   m2r_o[u],   0);
        check({tag, ":dst0"},   dst_o[u],   0);
        check({tag, ":data0"},  rdata_o[u], 0);
        check({tag, ":fault0"}, fault_o[u], 0);
    endtask

    // One transaction: waits WAIT edges with stall high (aligned requests only), then one result edge.
    task automatic op(input int u, input bit rd, input bit wr, input bit wb, input bit m2r,
                      input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst,
                      input string tag);
        int          key   = u * DEPTH + int'(a[9:2]);
        bit          req   = rd | wr;
        bit          al    = (a[1:0] == 2'b00);
        bit          drop  = req && !al;
        int          waits = (req && al && u == 0) ? 2 : 0;
        logic [31:0] exp_data = 32'd0;
        if (rd && !wr && al && mref.exists(key)) exp_data = mref[key];
        drive(u, rd, wr, wb, m2r, a, d, dst);
        #1;
        for (int e = 0; e < waits; e++) begin
            check({tag, ":stall1"}, stall_o[u], 1);
            @(negedge clk); #1;
            check_zero(u, {tag, ":bubble"});
        end
        check({tag, ":stall0"}, stall_o[u], 0);
        @(negedge clk); #1;
        check({tag, ":fault"}, fault_o[u], drop);
        check({tag, ":wb"},    wb_o[u],    drop ? 1'b0 : wb);
        check({tag, ":m2r"},   m2r_o[u],   drop ? 1'b0 : m2r);
        check({tag, ":dst"},   dst_o[u],   drop ? 5'd0 : dst);
        check({tag, ":data"},  rdata_o[u], exp_data);
        if (!drop) check({tag, ":alu"}, alu_o[u], a);
        if (wr && al) mref[key] = d;
        drive(u, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
    endtask

    initial begin
        logic [31:0] r, addr;
        logic [7:0]  pool [8];

        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        drive(0, 0, 1, 1, 0, 32'h40, 32'h1, 5'd3);
        #12;
        check("reset:stall", stall_o[0], 0);
        check_zero(0, "reset_u0");
        check_zero(1, "reset_u1");
        check("reset:alu", alu_o[0], 0);
        @(negedge clk); #1;
        check_zero(0, "reset_edge");
        drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        rst = 1'b0;

        op(0, 0, 0, 1, 0, 32'h1234, 32'd0, 5'd7, "alu_op");

        // Asynchronous reset away from any clock edge.
        #2; rst = 1'b1; #1;
        check("async:wb",  wb_o[0],  0);
        check("async:dst", dst_o[0], 0);
        check("async:alu", alu_o[0], 0);
        @(negedge clk); #1;
        rst = 1'b0;

        op(0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0, "store10");
        op(0, 1, 0, 1, 1, 32'h10, 32'd0,        5'd5, "load10");
        op(0, 1, 0, 1, 1, 32'h13, 32'd0,        5'd6, "misaligned");
        op(0, 0, 0, 0, 0, 32'd0,  32'd0,        5'd0, "after_fault");

        op(0, 0, 1, 0, 0, 32'h20, 32'h11111111, 5'd0, "store20_prior");
        drive(0, 0, 1, 0, 0, 32'h20, 32'hA5A5A5A5, 5'd0);
        #1;
        check("abort:stall_a", stall_o[0], 1);
        @(negedge clk); #1;
        check("abort:stall_b", stall_o[0], 1);
        #2; rst = 1'b1; #1;
        check("abort:stall_rst", stall_o[0], 0);
        check("abort:alu", alu_o[0], 0);
        check_zero(0, "abort");
        drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        op(0, 1, 0, 1, 1, 32'h20, 32'd0, 5'd9, "load20_after_abort");

        op(0, 0, 1, 0, 0, 32'h400, 32'h1, 5'd0, "store_wrap");
        op(0, 1, 0, 1, 1, 32'h0,   32'd0, 5'd4, "load_wrap");
        op(0, 1, 1, 0, 0, 32'h44,  32'h55AA00FF, 5'd2, "rd_wr_both");
        op(0, 1, 0, 1, 1, 32'h44,  32'd0, 5'd3, "load44");

        op(1, 0, 1, 0, 0, 32'h30, 32'hCAFEF00D, 5'd0, "w0_store");
        op(1, 1, 0, 1, 1, 32'h30, 32'd0,        5'd8, "w0_load");
        op(1, 1, 0, 1, 1, 32'h31, 32'd0,        5'd8, "w0_misaligned");

        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 8; k++) begin
                r = $urandom;
                pool[k] = r[7:0];
                r = $urandom;
                addr = {r[21:0], pool[k], 2'b00};
                op(u, 0, 1, 0, 0, addr, $urandom, 5'd0, "rnd_fill");
            end
            for (int n = 0; n < 40; n++) begin
                r = $urandom;
                addr = {$urandom_range(0, 4095), 20'd0} | {22'd0, pool[r[2:0]], 2'b00};
                if (r[5:3] == 3'd0) addr[1:0] = r[7:6] | 2'b01;
                op(u, r[8], r[9], r[10], r[11], addr, $urandom, r[16:12], "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, extra falling edges a data-memory access holds the pipeline (0..15).
REQ-002 Parameter DEPTH_LOG2, default 8, log2 of data-memory depth in 32-bit words.
REQ-003 clk  input  1  pipeline clock; all state updates on falling edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wb_in, mem_read_in, mem_write_in, mem2reg_in  input  1 each  control bundle from EX/MEM register.
REQ-006 ALU_result_in  input  32  memory byte address, or result passed to WB.
REQ-007 mem_write_data_in  input  32  store data.
REQ-008 dst_addr_in  input  5  destination register.
REQ-009 stall  output  1  hold request to upstream stages; EX/MEM bundle held stable while 1.
REQ-010 wb_out, mem2reg_out  output  1 each  MEM/WB control.
REQ-011 mem_read_data_out  output  32  loaded word, 0 when no load completed.
REQ-012 ALU_result_out  output  32  registered ALU_result_in.
REQ-013 dst_addr_out  output  5  registered dst_addr_in.
REQ-014 mem_fault  output  1  one-cycle flag: misaligned access dropped.

Function
REQ-015 Internal memory: 2^DEPTH_LOG2 x 32 words, indexed by ALU_result_in[DEPTH_LOG2+1:2]; upper address bits ignored (wrap); contents not reset.
REQ-016 Request = mem_read_in | mem_write_in; write has priority when both set (store performed, read data 0).
REQ-017 States IDLE, BUSY; 4-bit wait counter cnt.
REQ-018 Non-request bundle in IDLE: next falling edge loads wb, mem2reg, ALU_result, dst_addr to outputs, mem_read_data_out=0, stall=0 (latency 1).
REQ-019 stall = (IDLE & request & aligned & WAIT_CYCLES>0) | (BUSY & cnt!=0); combinational, 0 while rst high.
REQ-020 IDLE, aligned request, WAIT_CYCLES>0: edge -> BUSY, cnt=WAIT_CYCLES-1, outputs bubble (wb_out=0, mem2reg_out=0, dst_addr_out=0, data 0).
REQ-021 BUSY, cnt!=0: edge decrements cnt, outputs stay bubble.
REQ-022 BUSY, cnt==0 (stall=0): edge performs access, loads MEM/WB outputs from bundle (read data for loads), -> IDLE.
REQ-023 WAIT_CYCLES=0: aligned request completes on first edge from IDLE, stall never asserted.
REQ-024 Total memory-op latency = WAIT_CYCLES+1 falling edges.
REQ-025 Misaligned request (ALU_result_in[1:0]!=0): no stall, no memory change, edge gives bubble outputs with mem_fault=1 for one cycle.
REQ-026 Load immediately after store to same word returns new value.
REQ-027 Store: wb_out follows wb_in (normally 0); mem_read_data_out=0.

Reset
REQ-028 rst high: state IDLE, cnt=0, all outputs 0 immediately, independent of clk.
REQ-029 Reset during BUSY aborts access; pending store not written; memory otherwise unchanged.
REQ-030 First falling edge after rst release behaves as IDLE.

Verification
REQ-031 WAIT=2, store 0xDEADBEEF @0x10 -> stall 1 for 2 edges, bubbles, 3rd edge writes; then load @0x10, mem2reg=1, dst=5 -> after 3 edges mem_read_data_out=0xDEADBEEF, dst_addr_out=5, wb_out=1.
REQ-032 ALU op ALU_result_in=0x1234, dst=7, wb=1 -> next edge ALU_result_out=0x1234, dst_addr_out=7, stall never 1.
REQ-033 Load @0x13 -> stall 0, next edge mem_fault=1, wb_out=0; following cycle mem_fault=0.
REQ-034 Store 0xA5A5A5A5 @0x20, rst pulse during BUSY -> outputs 0 at once; later load @0x20 returns prior (pre-store) value.
REQ-035 DEPTH_LOG2=8: store 0x1 @0x400, load @0x0 -> returns 0x1 (wrap).
REQ-036 WAIT=0: store then load same word back-to-back -> each 1 edge, load returns stored value, stall always 0.
